// File: rtl/cdb_addsub_unit.sv
// cdb_addsub_unit: integer add/sub/logic/shift functional unit behind the
// add/sub reservation stations. Captures one dispatched operation while idle,
// executes it for LAT cycles, then requests the Common Data Bus and broadcasts
// {tag, result} for exactly one cycle once granted.
//
// Handshakes:
//   dispatch: `start` is accepted only on an edge where `busy` is low; any
//             `start` seen while `busy` is high is dropped without effect.
//   CDB:      `cdb_req` stays high until `cdb_grant` is sampled high; the
//             broadcast (`cdb_valid`/`conf` plus payload) appears for the one
//             cycle after that edge. `cdb_grant` is ignored while `cdb_req` is low.
//
// Optional feature macro: ADDSUB_SAT_EN
//   defined   -> ADD and SUB saturate on signed overflow (0x7FFF / 0x8000)
//   undefined -> ADD and SUB wrap mod 2^16
module cdb_addsub_unit #(
    parameter int unsigned LAT = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        start,
    input  logic [2:0]  tag,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        cdb_req,
    input  logic        cdb_grant,
    output logic [18:0] cdb_out,
    output logic        cdb_valid,
    output logic        conf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    state_t      state;
    logic [3:0]  cnt;
    logic [2:0]  tag_q;
    logic [2:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] res_q;

    logic [15:0] sum;
    logic [15:0] diff;
    logic [15:0] alu_res;

    // ALU on the captured operands; only sampled into res_q at the end of EXEC
    always_comb begin
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        alu_res = '0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum;
`ifdef ADDSUB_SAT_EN
                // same-sign operands producing an opposite-sign sum overflowed
                if ((a_q[15] == b_q[15]) && (sum[15] != a_q[15]))
                    alu_res = a_q[15] ? 16'h8000 : 16'h7FFF;
`endif
            end
            OP_SUB: begin
                alu_res = diff;
`ifdef ADDSUB_SAT_EN
                // opposite-sign operands with a result sign unlike a overflowed
                if ((a_q[15] != b_q[15]) && (diff[15] != a_q[15]))
                    alu_res = a_q[15] ? 16'h8000 : 16'h7FFF;
`endif
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SLT:  alu_res = {15'd0, ($signed(a_q) < $signed(b_q))};
            OP_SLL:  alu_res = a_q << b_q[3:0];
            OP_SRL:  alu_res = a_q >> b_q[3:0];
            default: alu_res = '0;
        endcase
    end

    // Control FSM with registered outputs; broadcast outputs default to zero each cycle
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tag_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            busy      <= 1'b0;
            cdb_req   <= 1'b0;
            cdb_out   <= '0;
            cdb_valid <= 1'b0;
            conf      <= 1'b0;
        end else begin
            cdb_out   <= '0;
            cdb_valid <= 1'b0;
            conf      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tag_q <= tag;
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res_q   <= alu_res;
                        cdb_req <= 1'b1;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cdb_grant) begin
                        cdb_out   <= {tag_q, res_q};
                        cdb_valid <= 1'b1;
                        conf      <= 1'b1;
                        cdb_req   <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    cdb_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
